// File: rtl/mdma_512bx32_64bwe_ram_if.sv
// mdma_512bx32_64bwe_ram_if
// Bus between the DMA engine (master) and the 512b x 32 buffer RAM (slave).
//   Master -> slave: wadr[4:0], wen, wben[7:0] (one bit per 64-bit lane), wdat[511:0],
//                    ren, radr[4:0]
//   Slave -> master: rdat[511:0], rsbe, rdbe (read-side error pulses)
interface mdma_512bx32_64bwe_ram_if;
  logic [4:0]   wadr;
  logic         wen;
  logic [7:0]   wben;
  logic [511:0] wdat;
  logic         ren;
  logic [4:0]   radr;
  logic [511:0] rdat;
  logic         rsbe;
  logic         rdbe;

  modport m (
    output wadr, wen, wben, wdat, ren, radr,
    input  rdat, rsbe, rdbe
  );

  modport s (
    input  wadr, wen, wben, wdat, ren, radr,
    output rdat, rsbe, rdbe
  );
endinterface

// File: rtl/mdma_512bx32_64bwe_ram_slv.sv
// mdma_512bx32_64bwe_ram_slv
// Slave side of the 512-bit x 32-entry DMA buffer RAM. Holds the array, performs
// 64-bit-lane-masked writes and fixed-latency reads, and returns read error flags
// with saturating counters.
//
// Parameters:
//   RD_LAT  read latency, ren edge to rdat update (1 or 2)
//   SAT_W   width of the saturating error counters
// Ports:
//   clk      single clock
//   rst      synchronous active-high reset
//   ram      slave modport: write/read requests in, rdat/rsbe/rdbe out
//   sbe_cnt  count of reads flagged rsbe (saturating)
//   dbe_cnt  count of reads flagged rdbe (saturating)
//   inj_sbe  tag the current write as single-bit-error (MDMA_RAM_ERR_INJ_EN only)
//   inj_dbe  tag the current write as double-bit-error (MDMA_RAM_ERR_INJ_EN only)
//
// Build option: define MDMA_RAM_ERR_INJ_EN to add per-entry error-injection tags.
// Without it rsbe, rdbe, sbe_cnt and dbe_cnt stay 0.
module mdma_512bx32_64bwe_ram_slv #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned SAT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mdma_512bx32_64bwe_ram_if.s  ram,
  output logic [SAT_W-1:0]     sbe_cnt,
  output logic [SAT_W-1:0]     dbe_cnt
`ifdef MDMA_RAM_ERR_INJ_EN
  ,
  input  logic                 inj_sbe,
  input  logic                 inj_dbe
`endif
);

  localparam int unsigned Depth = 32;
  localparam int unsigned Lanes = 8;
  localparam int unsigned LaneW = 64;
  localparam int unsigned DataW = Lanes * LaneW;

  if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
    $error("mdma_512bx32_64bwe_ram_slv: RD_LAT must be 1 or 2");
  end

  // ---------------------------------------------------------------------------
  // Storage array (not reset)
  // ---------------------------------------------------------------------------
  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (ram.wen) begin
      for (int i = 0; i < int'(Lanes); i++) begin
        if (ram.wben[i]) begin
          mem_q[ram.wadr][LaneW*i +: LaneW] <= ram.wdat[LaneW*i +: LaneW];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error-injection tags: bit 0 = sbe, bit 1 = dbe
  // ---------------------------------------------------------------------------
  logic rd_tag_sbe;
  logic rd_tag_dbe;

`ifdef MDMA_RAM_ERR_INJ_EN
  logic [1:0] tag_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        tag_q[i] <= 2'b00;
      end
    end else if (ram.wen) begin
      if (inj_dbe) begin
        tag_q[ram.wadr][1] <= 1'b1;
      end else if (inj_sbe) begin
        tag_q[ram.wadr][0] <= 1'b1;
      end else if (ram.wben == 8'hFF) begin
        // Only a full-entry clean write scrubs the tags; partial writes keep them.
        tag_q[ram.wadr] <= 2'b00;
      end
    end
  end

  assign rd_tag_sbe = tag_q[ram.radr][0];
  assign rd_tag_dbe = tag_q[ram.radr][1];
`else
  assign rd_tag_sbe = 1'b0;
  assign rd_tag_dbe = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read stage 1: array is sampled on the ren edge, so a same-cycle write to the
  // same address is not yet visible (old data is returned).
  // ---------------------------------------------------------------------------
  logic             s1_vld_q;
  logic [DataW-1:0] s1_data_q;
  logic             s1_sbe_q;
  logic             s1_dbe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_sbe_q  <= 1'b0;
      s1_dbe_q  <= 1'b0;
    end else begin
      s1_vld_q <= ram.ren;
      if (ram.ren) begin
        s1_data_q <= mem_q[ram.radr];
        s1_sbe_q  <= rd_tag_sbe;
        s1_dbe_q  <= rd_tag_dbe;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stage 2 (RD_LAT = 2)
  // ---------------------------------------------------------------------------
  logic             s2_vld;
  logic [DataW-1:0] s2_data;
  logic             s2_sbe;
  logic             s2_dbe;

  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld  <= 1'b0;
        s2_data <= '0;
        s2_sbe  <= 1'b0;
        s2_dbe  <= 1'b0;
      end else begin
        s2_vld <= s1_vld_q;
        if (s1_vld_q) begin
          s2_data <= s1_data_q;
          s2_sbe  <= s1_sbe_q;
          s2_dbe  <= s1_dbe_q;
        end
      end
    end
  end else begin : g_lat1
    assign s2_vld  = s1_vld_q;
    assign s2_data = s1_data_q;
    assign s2_sbe  = s1_sbe_q;
    assign s2_dbe  = s1_dbe_q;
  end

  // ---------------------------------------------------------------------------
  // Output register, flags and saturating counters
  // ---------------------------------------------------------------------------
  logic [DataW-1:0] rdat_q, rdat_d;
  logic             rsbe_q, rsbe_d;
  logic             rdbe_q, rdbe_d;
  logic [SAT_W-1:0] sbe_cnt_q, sbe_cnt_d;
  logic [SAT_W-1:0] dbe_cnt_q, dbe_cnt_d;

  always_comb begin
    rdat_d    = rdat_q;
    rsbe_d    = 1'b0;
    rdbe_d    = 1'b0;
    sbe_cnt_d = sbe_cnt_q;
    dbe_cnt_d = dbe_cnt_q;
    if (s2_vld) begin
      rdat_d = s2_data;
      // dbe wins when an entry carries both tags.
      rdbe_d = s2_dbe;
      rsbe_d = s2_sbe & ~s2_dbe;
    end
    if (rsbe_d && (sbe_cnt_q != '1)) begin
      sbe_cnt_d = sbe_cnt_q + SAT_W'(1);
    end
    if (rdbe_d && (dbe_cnt_q != '1)) begin
      dbe_cnt_d = dbe_cnt_q + SAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdat_q    <= '0;
      rsbe_q    <= 1'b0;
      rdbe_q    <= 1'b0;
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      rdat_q    <= rdat_d;
      rsbe_q    <= rsbe_d;
      rdbe_q    <= rdbe_d;
      sbe_cnt_q <= sbe_cnt_d;
      dbe_cnt_q <= dbe_cnt_d;
    end
  end

  assign ram.rdat = rdat_q;
  assign ram.rsbe = rsbe_q;
  assign ram.rdbe = rdbe_q;
  assign sbe_cnt  = sbe_cnt_q;
  assign dbe_cnt  = dbe_cnt_q;

endmodule
